// File: rtl/frame_buf_writer.sv
// Packs capture words into DDR bursts with per-frame buffer rotation; optional FRAME_BUF_OVF_CNT_EN adds a saturating ovf_cnt.
// Latency: 1 cycle from valid_data_ddr to fifo_wr/data_fifo_frame.
// Backpressure: none upstream; a word that meets fifo_full is dropped but still advances counters.
module frame_buf_writer #(
  parameter int DATA_W           = 64,
  parameter int ADDR_W           = 29,
  parameter int BURST_LEN        = 32,
  parameter int BURSTS_PER_FRAME = 14400,
  parameter int NUM_BUF          = 3
) (
  input  logic                      clk_100,
  input  logic                      reset_n,
  input  logic                      start_frame,
  input  logic                      valid_data_ddr,
  input  logic [DATA_W-1:0]         data_ddr,
  input  logic [31:0]               reg_addr_buf_1,
  input  logic [31:0]               reg_buf_stride,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W+ADDR_W+2:0]  data_fifo_frame,
  output logic                      end_frame,
  output logic                      frame_err,
  output logic [1:0]                wr_buf_idx,
  output logic [1:0]                rd_buf_idx,
  output logic                      ovf_flag,
  output logic [15:0]               ovf_cnt
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam int WC_W = $clog2(BURST_LEN);

  logic [0:0]        state;
  logic [WC_W-1:0]   word_cnt;
  logic [15:0]       burst_cnt;
  logic [ADDR_W-1:0] burst_addr;

  logic [1:0]        next_idx;
  logic [ADDR_W-1:0] cur_base;
  logic [ADDR_W-1:0] next_base;
  logic              take;
  logic              final_word;
  logic              restart;
  logic [WC_W-1:0]   cur_word;
  logic [15:0]       cur_burst;
  logic [ADDR_W-1:0] cur_addr;
  logic              last_burst;
  logic              last_frame;

  always_comb begin
    next_idx   = (wr_buf_idx == 2'(NUM_BUF - 1)) ? 2'd0 : wr_buf_idx + 2'd1;
    cur_base   = reg_addr_buf_1[ADDR_W-1:0] + reg_buf_stride[ADDR_W-1:0] * ADDR_W'(wr_buf_idx);
    next_base  = reg_addr_buf_1[ADDR_W-1:0] + reg_buf_stride[ADDR_W-1:0] * ADDR_W'(next_idx);
    take       = (state == ACTIVE) && valid_data_ddr;
    final_word = take && (word_cnt == WC_W'(BURST_LEN - 1))
                      && (burst_cnt == 16'(BURSTS_PER_FRAME - 1));
    // A start coinciding with the closing word is a clean hand-off, not an abort
    restart    = (state == ACTIVE) && start_frame && !final_word;
    cur_word   = restart ? '0 : word_cnt;
    cur_burst  = restart ? '0 : burst_cnt;
    cur_addr   = restart ? cur_base : burst_addr;
    last_burst = (cur_word == WC_W'(BURST_LEN - 1));
    last_frame = last_burst && (cur_burst == 16'(BURSTS_PER_FRAME - 1));
  end

  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      state           <= IDLE;
      word_cnt        <= '0;
      burst_cnt       <= '0;
      burst_addr      <= '0;
      wr_buf_idx      <= '0;
      rd_buf_idx      <= '0;
      fifo_wr         <= 1'b0;
      end_frame       <= 1'b0;
      frame_err       <= 1'b0;
      ovf_flag        <= 1'b0;
      data_fifo_frame <= '0;
    end else begin
      fifo_wr   <= 1'b0;
      end_frame <= 1'b0;
      frame_err <= restart;
      if (state == IDLE) begin
        if (start_frame) begin
          state      <= ACTIVE;
          word_cnt   <= '0;
          burst_cnt  <= '0;
          burst_addr <= cur_base;
        end
      end else begin
        if (restart) begin
          word_cnt   <= '0;
          burst_cnt  <= '0;
          burst_addr <= cur_base;
        end
        if (take) begin
          fifo_wr         <= !fifo_full;
          data_fifo_frame <= {last_burst, last_frame, 1'b1, cur_addr, data_ddr};
          end_frame       <= last_frame;
          if (fifo_full) ovf_flag <= 1'b1;
          if (last_frame) begin
            rd_buf_idx <= wr_buf_idx;
            wr_buf_idx <= next_idx;
            word_cnt   <= '0;
            burst_cnt  <= '0;
            if (start_frame) burst_addr <= next_base;
            else             state      <= IDLE;
          end else if (last_burst) begin
            word_cnt   <= '0;
            burst_cnt  <= cur_burst + 16'd1;
            burst_addr <= cur_addr + ADDR_W'(BURST_LEN);
          end else begin
            word_cnt   <= cur_word + WC_W'(1);
          end
        end
      end
    end
  end

`ifdef FRAME_BUF_OVF_CNT_EN
  always_ff @(posedge clk_100) begin
    if (!reset_n)                                   ovf_cnt <= '0;
    else if (take && fifo_full && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
  end
`else
  assign ovf_cnt = '0;
`endif

  generate
    if (ADDR_W < 32) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^{reg_addr_buf_1[31:ADDR_W], reg_buf_stride[31:ADDR_W]};
    end
  endgenerate

endmodule
